// File: rtl/mc_pkg.sv
// ----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle RISC-V style controller: the FSM state
// enumeration, the opcode constants the controller recognises, and the small
// code tables driven onto the datapath select lines (ALU operation, immediate
// format, result source, operand sources and access size).
// No ports; imported by multicycle_controller and alu_decoder.
// ----------------------------------------------------------------------------
package mc_pkg;

    // Controller states. The encoding is also what state_o exposes for debug.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR1    = 4'd11,
        JALR2    = 4'd12
    } state_t;

    // Major opcodes (instr[6:0]).
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ALU operation codes.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;

    // Immediate formats.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Result source select.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A / B selects.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Access size codes shared by MemWrite and RegWrite.
    localparam logic [1:0] SIZE_NONE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_BYTE = 2'b11;

    // Loads and stores encode their width in funct3; the unsigned load
    // variants and anything wider than a word produce no access at all.
    function automatic logic [1:0] size_from_funct3(input logic [2:0] funct3);
        logic [1:0] size;
        case (funct3)
            3'b000:  size = SIZE_BYTE;
            3'b001:  size = SIZE_HALF;
            3'b010:  size = SIZE_WORD;
            default: size = SIZE_NONE;
        endcase
        return size;
    endfunction

    // True for every opcode the controller knows how to sequence.
    function automatic logic opcode_known(input logic [6:0] opcode);
        return (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
               (opcode == OP_RTYPE)  || (opcode == OP_ITYPE) ||
               (opcode == OP_BRANCH) || (opcode == OP_JAL)   ||
               (opcode == OP_JALR);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Chooses the ALU operation from the controller state and the instruction's
// funct3 / bit 30. Purely combinational.
// Ports:
//   state    - current controller state
//   funct3   - instr[14:12]
//   funct7_5 - instr[30], distinguishes sub from add in R-type
//   alu_ctrl - ALU operation code (CONTROL_WIDTH bits)
// ----------------------------------------------------------------------------
module alu_decoder
    import mc_pkg::*;
#(
    parameter int CONTROL_WIDTH = 3
) (
    input  state_t                   state,
    input  logic [2:0]               funct3,
    input  logic                     funct7_5,
    output logic [CONTROL_WIDTH-1:0] alu_ctrl
);

    logic [2:0] code;

    // Address, PC-increment and jump states always add; only the two execute
    // states look at funct3, and the branch compare is always a subtract so
    // the zero flag reflects equality. I-type has no sub, so bit 30 is only
    // consulted in R-type.
    always_comb begin
        code = ALU_ADD;
        case (state)
            EXECR: begin
                case (funct3)
                    3'b000:  code = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b100:  code = ALU_XOR;
                    3'b110:  code = ALU_OR;
                    3'b111:  code = ALU_AND;
                    default: code = ALU_ADD;
                endcase
            end
            EXECI: begin
                case (funct3)
                    3'b001:  code = ALU_SLL;
                    3'b100:  code = ALU_XOR;
                    3'b110:  code = ALU_OR;
                    3'b111:  code = ALU_AND;
                    default: code = ALU_ADD;
                endcase
            end
            BRANCH:  code = ALU_SUB;
            default: code = ALU_ADD;
        endcase
    end

    assign alu_ctrl = CONTROL_WIDTH'(code);

endmodule

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
// Main control FSM for a multicycle RV32-style datapath. One state register
// sequences each instruction; the datapath selects and write strobes are
// decoded from the current state (plus the memory-ready and zero flags where
// a write depends on them).
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   instr_i            - instruction register contents
//   Zero_i             - ALU zero flag (branch decision)
//   mem_ready_i        - memory access completes this cycle
//   PCWrite_o          - PC load enable
//   AdrSrc_o           - memory address select (PC / ALUOut)
//   IRWrite_o          - instruction register and OldPC load enable
//   MemWrite_o         - store request with size
//   RegWrite_o         - register writeback request with size
//   ResultSrc_o        - result mux select
//   ALUSrcA_o/ALUSrcB_o- ALU operand selects
//   ImmSrc_o           - immediate format
//   ALUctrl_o          - ALU operation
//   illegal_o          - one-cycle pulse on an unsupported opcode
//   state_o            - current state encoding for debug
// ----------------------------------------------------------------------------
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    instr_i,
    input  logic                     Zero_i,
    input  logic                     mem_ready_i,
    output logic                     PCWrite_o,
    output logic                     AdrSrc_o,
    output logic                     IRWrite_o,
    output logic [1:0]               MemWrite_o,
    output logic [1:0]               RegWrite_o,
    output logic [1:0]               ResultSrc_o,
    output logic [1:0]               ALUSrcA_o,
    output logic [1:0]               ALUSrcB_o,
    output logic [1:0]               ImmSrc_o,
    output logic [CONTROL_WIDTH-1:0] ALUctrl_o,
    output logic                     illegal_o,
    output logic [3:0]               state_o
);

    state_t     state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    // Register fields and immediates belong to the datapath, not the control.
    assign unused_instr_bits = ^{instr_i[DATA_WIDTH-1:31], instr_i[29:15], instr_i[11:7]};

    assign state_o = state;

    // State register and next-state logic. Reset is asynchronous so an
    // instruction in flight is dropped immediately; the state sits in FETCH
    // and the first real fetch happens on the first edge after release.
    // Memory-facing states only advance when mem_ready_i is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (mem_ready_i) state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state <= MEMADR;
                        OP_RTYPE:          state <= EXECR;
                        OP_ITYPE:          state <= EXECI;
                        OP_BRANCH:         state <= BRANCH;
                        OP_JAL:            state <= JAL;
                        OP_JALR:           state <= JALR1;
                        default:           state <= FETCH;
                    endcase
                end
                MEMADR:   state <= (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
                MEMREAD:  if (mem_ready_i) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (mem_ready_i) state <= FETCH;
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                ALUWB:    state <= FETCH;
                BRANCH:   state <= FETCH;
                JAL:      state <= ALUWB;
                JALR1:    state <= JALR2;
                JALR2:    state <= ALUWB;
                default:  state <= FETCH;
            endcase
        end
    end

    alu_decoder #(
        .CONTROL_WIDTH(CONTROL_WIDTH)
    ) u_alu_decoder (
        .state    (state),
        .funct3   (funct3),
        .funct7_5 (instr_i[30]),
        .alu_ctrl (ALUctrl_o)
    );

    // Datapath controls for the current state. Everything defaults to zero so
    // each state only lists what it actually drives. FETCH writes IR and PC
    // only in the cycle the memory delivers the word, and the branch PC load
    // follows the zero flag directly so the decision lands in the same cycle.
    // While reset is high the state is already FETCH, but the write strobes
    // are masked explicitly so a ready memory cannot sneak a fetch through.
    always_comb begin
        PCWrite_o   = 1'b0;
        AdrSrc_o    = 1'b0;
        IRWrite_o   = 1'b0;
        MemWrite_o  = SIZE_NONE;
        RegWrite_o  = SIZE_NONE;
        ResultSrc_o = RES_ALUOUT;
        ALUSrcA_o   = SRCA_PC;
        ALUSrcB_o   = SRCB_RS2;
        ImmSrc_o    = IMM_I;
        illegal_o   = 1'b0;

        case (state)
            FETCH: begin
                AdrSrc_o    = 1'b0;
                ALUSrcA_o   = SRCA_PC;
                ALUSrcB_o   = SRCB_FOUR;
                ResultSrc_o = RES_ALURESULT;
                IRWrite_o   = mem_ready_i;
                PCWrite_o   = mem_ready_i;
            end
            DECODE: begin
                ALUSrcA_o = SRCA_OLDPC;
                ALUSrcB_o = SRCB_IMM;
                ImmSrc_o  = (opcode == OP_JAL) ? IMM_J : IMM_B;
                illegal_o = !opcode_known(opcode);
            end
            MEMADR: begin
                ALUSrcA_o = SRCA_RS1;
                ALUSrcB_o = SRCB_IMM;
                ImmSrc_o  = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            MEMREAD: begin
                AdrSrc_o = 1'b1;
            end
            MEMWB: begin
                ResultSrc_o = RES_MEMDATA;
                RegWrite_o  = size_from_funct3(funct3);
            end
            MEMWRITE: begin
                AdrSrc_o   = 1'b1;
                MemWrite_o = size_from_funct3(funct3);
            end
            EXECR: begin
                ALUSrcA_o = SRCA_RS1;
                ALUSrcB_o = SRCB_RS2;
            end
            EXECI: begin
                ALUSrcA_o = SRCA_RS1;
                ALUSrcB_o = SRCB_IMM;
                ImmSrc_o  = IMM_I;
            end
            ALUWB: begin
                ResultSrc_o = RES_ALUOUT;
                RegWrite_o  = SIZE_WORD;
            end
            BRANCH: begin
                ALUSrcA_o   = SRCA_RS1;
                ALUSrcB_o   = SRCB_RS2;
                ResultSrc_o = RES_ALUOUT;
                case (funct3)
                    3'b000:  PCWrite_o = Zero_i;
                    3'b001:  PCWrite_o = !Zero_i;
                    default: PCWrite_o = 1'b0;
                endcase
            end
            JAL, JALR2: begin
                PCWrite_o   = 1'b1;
                ResultSrc_o = RES_ALUOUT;
                ALUSrcA_o   = SRCA_OLDPC;
                ALUSrcB_o   = SRCB_FOUR;
            end
            JALR1: begin
                ALUSrcA_o = SRCA_RS1;
                ALUSrcB_o = SRCB_IMM;
                ImmSrc_o  = IMM_I;
            end
            default: begin
                PCWrite_o = 1'b0;
            end
        endcase

        if (rst) begin
            PCWrite_o  = 1'b0;
            IRWrite_o  = 1'b0;
            MemWrite_o = SIZE_NONE;
            RegWrite_o = SIZE_NONE;
            illegal_o  = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the instruction word.
REQ-002 Parameter CONTROL_WIDTH, default 3, SHALL set the width of the ALU control code.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Port instr_i  input  DATA_WIDTH  SHALL carry the instruction-register contents.
REQ-006 Port Zero_i  input  1  SHALL carry the ALU zero flag.
REQ-007 Port mem_ready_i  input  1  SHALL flag that the memory access completes this cycle.
REQ-008 Port PCWrite_o  output  1  SHALL enable the PC register load.
REQ-009 Port AdrSrc_o  output  1  SHALL select the memory address: 0 = PC, 1 = ALUOut.
REQ-010 Port IRWrite_o  output  1  SHALL enable the instruction register and OldPC load.
REQ-011 Port MemWrite_o  output  2  SHALL request a store: 00 none, 01 word, 10 half, 11 byte.
REQ-012 Port RegWrite_o  output  2  SHALL request a writeback: 00 none, 01 word, 10 half, 11 byte.
REQ-013 Port ResultSrc_o  output  2  SHALL select the result: 00 ALUOut, 01 memory data, 10 ALU result.
REQ-014 Port ALUSrcA_o  output  2  SHALL select ALU operand A: 00 PC, 01 OldPC, 10 rs1 register.
REQ-015 Port ALUSrcB_o  output  2  SHALL select ALU operand B: 00 rs2 register, 01 immediate, 10 constant 4.
REQ-016 Port ImmSrc_o  output  2  SHALL select the immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-017 Port ALUctrl_o  output  CONTROL_WIDTH  SHALL give the ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll.
REQ-018 Port illegal_o  output  1  SHALL pulse for one cycle on an unsupported opcode.
REQ-019 Port state_o  output  4  SHALL expose the current state encoding for debug.

Function
REQ-020 The controller SHALL be a state machine with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR1 and JALR2.
REQ-021 Every output not set by a state SHALL default to zero.
REQ-022 FETCH: AdrSrc=0, A=00, B=10, add, ResultSrc=10; IRWrite and PCWrite only when mem_ready_i=1; then go to DECODE, else hold.
REQ-023 DECODE: A=01, B=01, add; ImmSrc=11 for opcode 1101111, else 10.
REQ-024 DECODE next state by opcode: 0000011 or 0100011 to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1100011 to BRANCH; 1101111 to JAL; 1100111 to JALR1; any other opcode to FETCH with illegal_o=1.
REQ-025 MEMADR: A=10, B=01, add, ImmSrc=00 for loads or 01 for stores; then go to MEMREAD for loads or MEMWRITE for stores.
REQ-026 MEMREAD: AdrSrc=1; hold until mem_ready_i=1, then go to MEMWB.
REQ-027 MEMWB: ResultSrc=01; funct3 000, 001 and 010 SHALL give RegWrite 11, 10 and 01; other funct3 values SHALL give 00; then go to FETCH.
REQ-028 MEMWRITE: AdrSrc=1; MemWrite from funct3 by the same map as REQ-027, asserted while waiting; on mem_ready_i=1 go to FETCH.
REQ-029 EXECR: A=10, B=00.
REQ-030 EXECR ALU code by funct3: 000 gives sub if instr_i[30]=1, else add; 100 gives xor; 110 gives or; 111 gives and; 001 gives sll; all others give add.
REQ-031 EXECI: A=10, B=01, ImmSrc=00; funct3 001 gives sll, 100 xor, 110 or, 111 and, all others add.
REQ-032 EXECR and EXECI SHALL both go next to ALUWB.
REQ-033 ALUWB: ResultSrc=00, RegWrite=01; then go to FETCH.
REQ-034 BRANCH: A=10, B=00, sub, ResultSrc=00; then go to FETCH.
REQ-035 BRANCH PCWrite SHALL be combinational: Zero_i for funct3 000, !Zero_i for 001, 0 otherwise.
REQ-036 JAL: PCWrite=1, ResultSrc=00, A=01, B=10, add; then go to ALUWB.
REQ-037 JALR1: A=10, B=01, ImmSrc=00, add; then go to JALR2.
REQ-038 JALR2: PCWrite=1, ResultSrc=00, A=01, B=10, add; then go to ALUWB.
REQ-039 Latency with zero memory wait SHALL be: load 5 cycles; store, R, I and jal 4; branch 3; jalr 5; each memory wait adds one cycle.
REQ-040 mem_ready_i SHALL be ignored outside FETCH, MEMREAD and MEMWRITE.

Reset
REQ-041 While rst=1, the state SHALL be FETCH and PCWrite, IRWrite, MemWrite, RegWrite and illegal_o SHALL be forced to 0.
REQ-042 Reset asserted mid-instruction SHALL abandon the instruction with no further writes.
REQ-043 The first fetch SHALL occur on the first rising edge with rst=0.

Structure
REQ-044 Package mc_pkg SHALL hold the state enum, the opcode constants and the ALU, ImmSrc, ResultSrc and size codes.
REQ-045 Sub-module alu_decoder SHALL map state, funct3 and instr_i[30] to ALUctrl_o.

Verification
REQ-046 Reset mid-MEMWRITE with mem_ready_i=0 -> state_o=FETCH immediately; MemWrite_o=00 while rst=1.
REQ-047 lw (0x0000A083), mem_ready_i=1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite_o=01 in MEMWB only.
REQ-048 sb, mem_ready_i=0 for 3 cycles in MEMWRITE -> MemWrite_o=11 held 4 cycles; exactly one FETCH IRWrite afterwards.
REQ-049 sub (funct7=0100000), then beq with Zero_i=0 and then 1 -> sub uses ALUctrl 001 in EXECR; beq gives PCWrite_o 0, then 1 in BRANCH.
REQ-050 jal then jalr -> jal: PCWrite in JAL, RegWrite 01 in ALUWB, 4 cycles; jalr: PCWrite in JALR2 only, 5 cycles.
REQ-051 Opcode 0x7F -> illegal_o=1 for exactly one cycle in DECODE; next state FETCH; no register or memory write.
